// File: rtl/iob_soc_sim_watch_monitor.sv
// Simulation watch monitor: snoops an IOb-native bus, counts address/mask watchpoint hits
// and raises a sticky halt on hit thresholds or CPU trap edges. Configured via an IOb CSR slave.
module iob_soc_sim_watch_monitor #(
  parameter int N_WATCH    = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int CSR_ADDR_W = 6
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  input  logic                    cke_i,
  input  logic                    snoop_valid_i,
  input  logic                    snoop_ready_i,
  input  logic [ADDR_W-1:0]       snoop_addr_i,
  input  logic [DATA_W-1:0]       snoop_wdata_i,
  input  logic [DATA_W/8-1:0]     snoop_wstrb_i,
  input  logic                    trap_i,
  input  logic                    iob_avalid_i,
  input  logic [CSR_ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]       iob_wdata_i,
  input  logic [DATA_W/8-1:0]     iob_wstrb_i,
  output logic [DATA_W-1:0]       iob_rdata_o,
  output logic                    iob_rvalid_o,
  output logic                    iob_ready_o,
  output logic [N_WATCH-1:0]      hit_o,
  output logic                    halt_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int BLK_W  = CSR_ADDR_W - 3;
  localparam logic [3:0] CAUSE_TRAP = 4'(N_WATCH);

  localparam logic [2:0] R_ADDR   = 3'd0;
  localparam logic [2:0] R_MASK   = 3'd1;
  localparam logic [2:0] R_CTRL   = 3'd2;
  localparam logic [2:0] R_THRESH = 3'd3;
  localparam logic [2:0] R_COUNT  = 3'd4;
  localparam logic [2:0] R_LWD    = 3'd5;
  localparam logic [2:0] R_STATUS = 3'd0;
  localparam logic [2:0] R_GCTRL  = 3'd1;
  localparam logic [2:0] R_CYCLES = 3'd2;

  // watchpoint configuration and state
  logic [N_WATCH-1:0][ADDR_W-1:0] wp_addr;
  logic [N_WATCH-1:0][ADDR_W-1:0] wp_mask;
  logic [N_WATCH-1:0][3:0]        wp_ctrl;
  logic [N_WATCH-1:0][CNT_W-1:0]  wp_thresh;
  logic [N_WATCH-1:0][CNT_W-1:0]  wp_count;
  logic [N_WATCH-1:0][DATA_W-1:0] wp_lwd;
  logic [N_WATCH-1:0][CNT_W-1:0]  cnt_upd;

  logic                 ready_q;
  logic                 rvalid_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [DATA_W-1:0]    rd_mux;

  logic                 s0_v;
  logic [ADDR_W-1:0]    s0_addr;
  logic [DATA_W-1:0]    s0_wdata;
  logic [STRB_W-1:0]    s0_wstrb;

  logic [N_WATCH-1:0]   hit_c;
  logic [N_WATCH-1:0]   hit_q;
  logic [N_WATCH-1:0]   wr_count;
  logic [N_WATCH-1:0]   chan_halt;

  logic                 halt_q;
  logic [3:0]           cause_q;
  logic                 hot_q;
  logic                 trap_q;
  logic [31:0]          cycles_q;

  logic                 csr_acc;
  logic                 csr_wr;
  logic                 csr_rd;
  logic [BLK_W-1:0]     blk;
  logic [2:0]           rsel;
  logic                 g_sel;
  logic                 trap_halt;
  logic                 halt_clr;
  logic                 halt_set;
  logic [3:0]           new_cause;
  logic                 snoop_acc;

  assign iob_ready_o  = ready_q & cke_i;
  assign iob_rvalid_o = rvalid_q;
  assign iob_rdata_o  = rdata_q;
  assign hit_o        = hit_q;
  assign halt_o       = halt_q;

  assign csr_acc   = iob_avalid_i & iob_ready_o;
  assign csr_wr    = csr_acc & (|iob_wstrb_i);
  assign csr_rd    = csr_acc & ~(|iob_wstrb_i);
  assign blk       = iob_addr_i[CSR_ADDR_W-1:3];
  assign rsel      = iob_addr_i[2:0];
  assign g_sel     = (blk == BLK_W'(N_WATCH));
  assign snoop_acc = snoop_valid_i & snoop_ready_i;

  assign trap_halt = trap_i & ~trap_q & hot_q;
  assign halt_clr  = csr_wr & g_sel & (rsel == R_GCTRL) & iob_wstrb_i[0] & iob_wdata_i[1];
  assign halt_set  = (|chan_halt) | trap_halt;

  // match, counter update and halt detection for the stage-1 access
  always_comb begin
    hit_c     = '0;
    wr_count  = '0;
    chan_halt = '0;
    cnt_upd   = wp_count;
    new_cause = CAUSE_TRAP;
    for (int k = 0; k < N_WATCH; k++) begin
      wr_count[k] = csr_wr && (blk == BLK_W'(k)) && (rsel == R_COUNT);
      hit_c[k] = s0_v && wp_ctrl[k][0]
                 && (((s0_addr ^ wp_addr[k]) & wp_mask[k]) == '0)
                 && ((|s0_wstrb) ? wp_ctrl[k][1] : wp_ctrl[k][2]);
      if (wr_count[k])
        cnt_upd[k] = '0;
      else if (hit_c[k] && !halt_q && (wp_count[k] != '1))
        cnt_upd[k] = wp_count[k] + CNT_W'(1);
      chan_halt[k] = hit_c[k] && !halt_q && !wr_count[k] && wp_ctrl[k][3]
                     && (wp_thresh[k] != '0) && (cnt_upd[k] == wp_thresh[k]);
    end
    for (int k = N_WATCH - 1; k >= 0; k--) begin
      if (chan_halt[k]) new_cause = 4'(k);
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_WATCH; k++) begin
      if (blk == BLK_W'(k)) begin
        case (rsel)
          R_ADDR:   rd_mux = DATA_W'(wp_addr[k]);
          R_MASK:   rd_mux = DATA_W'(wp_mask[k]);
          R_CTRL:   rd_mux = DATA_W'(wp_ctrl[k]);
          R_THRESH: rd_mux = DATA_W'(wp_thresh[k]);
          R_COUNT:  rd_mux = DATA_W'(wp_count[k]);
          R_LWD:    rd_mux = wp_lwd[k];
          default:  ;
        endcase
      end
    end
    if (g_sel) begin
      case (rsel)
        R_STATUS: rd_mux = DATA_W'({cause_q, 7'b0, halt_q});
        R_GCTRL:  rd_mux = DATA_W'(hot_q);
        R_CYCLES: rd_mux = DATA_W'(cycles_q);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wp_addr   <= '0;
      wp_mask   <= '0;
      wp_ctrl   <= '0;
      wp_thresh <= '0;
      wp_count  <= '0;
      wp_lwd    <= '0;
    end else if (cke_i) begin
      for (int k = 0; k < N_WATCH; k++) begin
        if (csr_wr && (blk == BLK_W'(k))) begin
          case (rsel)
            R_ADDR: begin
              for (int i = 0; i < ADDR_W; i++)
                if (iob_wstrb_i[i/8]) wp_addr[k][i] <= iob_wdata_i[i];
            end
            R_MASK: begin
              for (int i = 0; i < ADDR_W; i++)
                if (iob_wstrb_i[i/8]) wp_mask[k][i] <= iob_wdata_i[i];
            end
            R_CTRL: begin
              if (iob_wstrb_i[0]) wp_ctrl[k] <= iob_wdata_i[3:0];
            end
            R_THRESH: begin
              for (int i = 0; i < CNT_W; i++)
                if (iob_wstrb_i[i/8]) wp_thresh[k][i] <= iob_wdata_i[i];
            end
            default: ;
          endcase
        end
        wp_count[k] <= cnt_upd[k];
        if (hit_c[k] && (|s0_wstrb) && !halt_q) wp_lwd[k] <= s0_wdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      s0_v     <= 1'b0;
      s0_addr  <= '0;
      s0_wdata <= '0;
      s0_wstrb <= '0;
      hit_q    <= '0;
      halt_q   <= 1'b0;
      cause_q  <= '0;
      hot_q    <= 1'b0;
      trap_q   <= 1'b0;
      cycles_q <= '0;
    end else if (cke_i) begin
      ready_q  <= 1'b1;
      rvalid_q <= csr_rd;
      if (csr_rd) rdata_q <= rd_mux;
      s0_v <= snoop_acc;
      if (snoop_acc) begin
        s0_addr  <= snoop_addr_i;
        s0_wdata <= snoop_wdata_i;
        s0_wstrb <= snoop_wstrb_i;
      end
      hit_q  <= hit_c;
      trap_q <= trap_i;
      if (!halt_q) cycles_q <= cycles_q + 32'd1;
      if (csr_wr && g_sel && (rsel == R_GCTRL) && iob_wstrb_i[0]) hot_q <= iob_wdata_i[0];
      // a fresh halt condition beats a simultaneous clear
      if (halt_set && (!halt_q || halt_clr)) begin
        halt_q  <= 1'b1;
        cause_q <= new_cause;
      end else if (halt_clr) begin
        halt_q  <= 1'b0;
        cause_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_iob_soc_sim_watch_monitor.sv
// Directed bench for iob_soc_sim_watch_monitor (N_WATCH=4, CNT_W=4 so saturation is reachable).
module tb_iob_soc_sim_watch_monitor;

  logic        clk_i = 1'b0;
  logic        arst_n_i = 1'b0;
  logic        cke_i = 1'b1;
  logic        snoop_valid_i = 1'b0;
  logic        snoop_ready_i = 1'b0;
  logic [31:0] snoop_addr_i = '0;
  logic [31:0] snoop_wdata_i = '0;
  logic [3:0]  snoop_wstrb_i = '0;
  logic        trap_i = 1'b0;
  logic        iob_avalid_i = 1'b0;
  logic [5:0]  iob_addr_i = '0;
  logic [31:0] iob_wdata_i = '0;
  logic [3:0]  iob_wstrb_i = '0;
  logic [31:0] iob_rdata_o;
  logic        iob_rvalid_o;
  logic        iob_ready_o;
  logic [3:0]  hit_o;
  logic        halt_o;

  int nchk = 0;
  int nfail = 0;

  iob_soc_sim_watch_monitor #(
    .N_WATCH(4), .ADDR_W(32), .DATA_W(32), .CNT_W(4), .CSR_ADDR_W(6)
  ) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
    .snoop_valid_i(snoop_valid_i), .snoop_ready_i(snoop_ready_i),
    .snoop_addr_i(snoop_addr_i), .snoop_wdata_i(snoop_wdata_i), .snoop_wstrb_i(snoop_wstrb_i),
    .trap_i(trap_i),
    .iob_avalid_i(iob_avalid_i), .iob_addr_i(iob_addr_i), .iob_wdata_i(iob_wdata_i),
    .iob_wstrb_i(iob_wstrb_i), .iob_rdata_o(iob_rdata_o), .iob_rvalid_o(iob_rvalid_o),
    .iob_ready_o(iob_ready_o), .hit_o(hit_o), .halt_o(halt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // all drivers start and end on a falling edge
  task automatic csr_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    iob_avalid_i = 1'b1; iob_addr_i = a; iob_wdata_i = d; iob_wstrb_i = s;
    @(negedge clk_i);
    iob_avalid_i = 1'b0; iob_wstrb_i = '0;
  endtask

  task automatic csr_read(input logic [5:0] a, output logic [31:0] d, output logic rv_ok);
    logic rv1;
    iob_avalid_i = 1'b1; iob_addr_i = a; iob_wdata_i = '0; iob_wstrb_i = '0;
    @(negedge clk_i);
    iob_avalid_i = 1'b0;
    rv1 = iob_rvalid_o;
    d = iob_rdata_o;
    @(negedge clk_i);
    rv_ok = rv1 && !iob_rvalid_o;
  endtask

  task automatic snoop(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [3:0] h);
    snoop_valid_i = 1'b1; snoop_ready_i = 1'b1;
    snoop_addr_i = a; snoop_wdata_i = d; snoop_wstrb_i = s;
    @(negedge clk_i);
    snoop_valid_i = 1'b0;
    @(negedge clk_i);
    h = hit_o;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic rv;
    arst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    nchk++; if ({iob_ready_o, iob_rvalid_o, halt_o} !== 3'b000) begin
      nfail++; $display("FAIL reset_ctl: got ready/rvalid/halt=%b required 000", {iob_ready_o, iob_rvalid_o, halt_o});
    end
    nchk++; if (iob_rdata_o !== 32'h0) begin
      nfail++; $display("FAIL reset_rdata: got %h required 0", iob_rdata_o);
    end
    nchk++; if (hit_o !== 4'h0) begin
      nfail++; $display("FAIL reset_hit: got %b required 0000", hit_o);
    end
    arst_n_i = 1'b1;
    @(negedge clk_i);
    nchk++; if (iob_ready_o !== 1'b1) begin
      nfail++; $display("FAIL ready_after_reset: got %b required 1", iob_ready_o);
    end
    csr_read(6'd32, d, rv);
    nchk++; if (d !== 32'h0) begin
      nfail++; $display("FAIL reset_status: got %h required 0", d);
    end
  endtask

  task automatic test_rw_map();
    logic [31:0] d;
    logic rv;
    csr_write(6'd0, 32'h8000_0100, 4'hF);
    nchk++; if (iob_rvalid_o !== 1'b0) begin
      nfail++; $display("FAIL write_no_rvalid: got %b required 0", iob_rvalid_o);
    end
    csr_write(6'd1, 32'hFFFF_FFFC, 4'hF);
    csr_read(6'd0, d, rv);
    nchk++; if (d !== 32'h8000_0100) begin
      nfail++; $display("FAIL addr0_readback: got %h required 80000100", d);
    end
    nchk++; if (rv !== 1'b1) begin
      nfail++; $display("FAIL addr0_rvalid_pulse: got %b required 1", rv);
    end
    csr_read(6'd1, d, rv);
    nchk++; if (d !== 32'hFFFF_FFFC || rv !== 1'b1) begin
      nfail++; $display("FAIL mask0_readback: got %h rv %b required fffffffc rv 1", d, rv);
    end
    csr_read(6'd7, d, rv);
    nchk++; if (d !== 32'h0 || rv !== 1'b1) begin
      nfail++; $display("FAIL unmapped_ch0_r7: got %h rv %b required 0 rv 1", d, rv);
    end
    csr_write(6'd24, 32'h1122_3344, 4'hF);
    csr_write(6'd24, 32'hAABB_CCDD, 4'b0010);
    csr_read(6'd24, d, rv);
    nchk++; if (d !== 32'h1122_CC44) begin
      nfail++; $display("FAIL byte_strobe: got %h required 1122cc44", d);
    end
    csr_read(6'd40, d, rv);
    nchk++; if (d !== 32'h0) begin
      nfail++; $display("FAIL unmapped_block: got %h required 0", d);
    end
    csr_read(6'd35, d, rv);
    nchk++; if (d !== 32'h0) begin
      nfail++; $display("FAIL unmapped_global: got %h required 0", d);
    end
  endtask

  task automatic test_write_match();
    logic [31:0] d;
    logic rv;
    logic [3:0] h;
    csr_write(6'd2, 32'h3, 4'hF);
    csr_write(6'd3, 32'h0, 4'hF);
    snoop(32'h8000_0102, 32'hDEAD_BEEF, 4'hF, h);
    nchk++; if (h !== 4'b0001) begin
      nfail++; $display("FAIL write_hit: got %b required 0001", h);
    end
    @(negedge clk_i);
    nchk++; if (hit_o !== 4'b0000) begin
      nfail++; $display("FAIL hit_one_cycle: got %b required 0000", hit_o);
    end
    csr_read(6'd4, d, rv);
    nchk++; if (d !== 32'd1) begin
      nfail++; $display("FAIL count0_after_write: got %0d required 1", d);
    end
    csr_read(6'd5, d, rv);
    nchk++; if (d !== 32'hDEAD_BEEF) begin
      nfail++; $display("FAIL last_wdata0: got %h required deadbeef", d);
    end
    snoop(32'h8000_0102, 32'h0, 4'h0, h);
    nchk++; if (h !== 4'b0000) begin
      nfail++; $display("FAIL read_no_hit: got %b required 0000", h);
    end
    snoop(32'h8000_0104, 32'h1234_5678, 4'hF, h);
    nchk++; if (h !== 4'b0000) begin
      nfail++; $display("FAIL outside_mask_no_hit: got %b required 0000", h);
    end
    csr_read(6'd4, d, rv);
    nchk++; if (d !== 32'd1) begin
      nfail++; $display("FAIL count0_unchanged: got %0d required 1", d);
    end
  endtask

  task automatic test_threshold();
    logic [31:0] d;
    logic rv;
    logic [3:0] h;
    csr_write(6'd8,  32'h0000_2000, 4'hF);
    csr_write(6'd9,  32'hFFFF_FF00, 4'hF);
    csr_write(6'd10, 32'hD, 4'hF);
    csr_write(6'd11, 32'd3, 4'hF);
    csr_write(6'd16, 32'h0000_2000, 4'hF);
    csr_write(6'd17, 32'hFFFF_FF00, 4'hF);
    csr_write(6'd18, 32'hD, 4'hF);
    csr_write(6'd19, 32'd3, 4'hF);
    snoop(32'h0000_2010, 32'h0, 4'h0, h);
    nchk++; if (h !== 4'b0110) begin
      nfail++; $display("FAIL dual_hit: got %b required 0110", h);
    end
    snoop(32'h0000_2010, 32'h0, 4'h0, h);
    nchk++; if (halt_o !== 1'b0) begin
      nfail++; $display("FAIL halt_early: got %b required 0", halt_o);
    end
    snoop(32'h0000_2010, 32'h0, 4'h0, h);
    nchk++; if (halt_o !== 1'b1) begin
      nfail++; $display("FAIL halt_on_thresh: got %b required 1", halt_o);
    end
    csr_read(6'd32, d, rv);
    nchk++; if (d !== 32'h101) begin
      nfail++; $display("FAIL status_cause1: got %h required 101", d);
    end
    csr_read(6'd20, d, rv);
    nchk++; if (d !== 32'd3) begin
      nfail++; $display("FAIL count2: got %0d required 3", d);
    end
    snoop(32'h0000_2010, 32'h0, 4'h0, h);
    nchk++; if (h !== 4'b0110) begin
      nfail++; $display("FAIL hit_while_halted: got %b required 0110", h);
    end
    csr_read(6'd12, d, rv);
    nchk++; if (d !== 32'd3) begin
      nfail++; $display("FAIL count1_frozen: got %0d required 3", d);
    end
    csr_write(6'd33, 32'h2, 4'hF);
    nchk++; if (halt_o !== 1'b0) begin
      nfail++; $display("FAIL halt_clear: got %b required 0", halt_o);
    end
    csr_read(6'd32, d, rv);
    nchk++; if (d !== 32'h0) begin
      nfail++; $display("FAIL status_cleared: got %h required 0", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic rv;
    int hits;
    csr_write(6'd24, 32'h0000_3000, 4'hF);
    csr_write(6'd25, 32'hFFFF_FFFF, 4'hF);
    csr_write(6'd26, 32'h7, 4'hF);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      snoop_valid_i = 1'b1; snoop_ready_i = 1'b1;
      snoop_addr_i = 32'h0000_3000;
      snoop_wstrb_i = i[0] ? 4'hF : 4'h0;
      snoop_wdata_i = 32'hA000_0000 | 32'(i);
      @(negedge clk_i);
      if (hit_o[3]) hits++;
    end
    snoop_valid_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      if (hit_o[3]) hits++;
    end
    nchk++; if (hits != 20) begin
      nfail++; $display("FAIL b2b_hit_pulses: got %0d required 20", hits);
    end
    csr_read(6'd28, d, rv);
    nchk++; if (d !== 32'd15) begin
      nfail++; $display("FAIL count_saturate: got %0d required 15", d);
    end
    csr_read(6'd29, d, rv);
    nchk++; if (d !== 32'hA000_0013) begin
      nfail++; $display("FAIL b2b_last_wdata: got %h required a0000013", d);
    end
    // COUNT write lands on the same edge as a hit
    snoop_valid_i = 1'b1; snoop_ready_i = 1'b1;
    snoop_addr_i = 32'h0000_3000; snoop_wstrb_i = 4'h0;
    @(negedge clk_i);
    snoop_valid_i = 1'b0;
    iob_avalid_i = 1'b1; iob_addr_i = 6'd28; iob_wdata_i = 32'h0; iob_wstrb_i = 4'hF;
    @(negedge clk_i);
    iob_avalid_i = 1'b0; iob_wstrb_i = 4'h0;
    nchk++; if (hit_o[3] !== 1'b1) begin
      nfail++; $display("FAIL collision_hit: got %b required 1", hit_o[3]);
    end
    csr_read(6'd28, d, rv);
    nchk++; if (d !== 32'd0) begin
      nfail++; $display("FAIL collision_count: got %0d required 0", d);
    end
  endtask

  task automatic test_cke();
    logic [31:0] c1, c2, d;
    logic rv;
    int hits;
    hits = 0;
    csr_read(6'd34, c1, rv);
    cke_i = 1'b0;
    snoop_valid_i = 1'b1; snoop_ready_i = 1'b1;
    snoop_addr_i = 32'h8000_0100; snoop_wdata_i = 32'h5555_5555; snoop_wstrb_i = 4'hF;
    repeat (5) begin
      @(negedge clk_i);
      snoop_valid_i = 1'b0;
      if (hit_o[0]) hits++;
    end
    cke_i = 1'b1;
    csr_read(6'd34, c2, rv);
    repeat (2) begin
      @(negedge clk_i);
      if (hit_o[0]) hits++;
    end
    nchk++; if (c2 - c1 !== 32'd2) begin
      nfail++; $display("FAIL cke_cycles_frozen: got delta %0d required 2", c2 - c1);
    end
    nchk++; if (hits != 0) begin
      nfail++; $display("FAIL cke_no_capture: got %0d hits required 0", hits);
    end
    csr_read(6'd4, d, rv);
    nchk++; if (d !== 32'd1) begin
      nfail++; $display("FAIL cke_count0: got %0d required 1", d);
    end
  endtask

  task automatic test_trap();
    logic [31:0] c1, c2, d;
    logic rv;
    logic [3:0] h;
    trap_i = 1'b1;
    @(negedge clk_i);
    nchk++; if (halt_o !== 1'b0) begin
      nfail++; $display("FAIL trap_disabled: got %b required 0", halt_o);
    end
    trap_i = 1'b0;
    @(negedge clk_i);
    csr_write(6'd33, 32'h1, 4'hF);
    csr_read(6'd34, c1, rv);
    csr_read(6'd34, c2, rv);
    nchk++; if (c2 - c1 !== 32'd2) begin
      nfail++; $display("FAIL cycles_running: got delta %0d required 2", c2 - c1);
    end
    trap_i = 1'b1;
    @(negedge clk_i);
    nchk++; if (halt_o !== 1'b1) begin
      nfail++; $display("FAIL trap_halt: got %b required 1", halt_o);
    end
    csr_read(6'd32, d, rv);
    nchk++; if (d !== 32'h401) begin
      nfail++; $display("FAIL trap_cause: got %h required 401", d);
    end
    csr_read(6'd34, c1, rv);
    csr_read(6'd34, c2, rv);
    nchk++; if (c2 !== c1) begin
      nfail++; $display("FAIL cycles_frozen: got %h then %h required equal", c1, c2);
    end
    snoop(32'h0000_2010, 32'h0, 4'h0, h);
    csr_read(6'd32, d, rv);
    nchk++; if (d !== 32'h401) begin
      nfail++; $display("FAIL cause_sticky: got %h required 401", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic rv;
    int rvs;
    iob_avalid_i = 1'b1; iob_addr_i = 6'd32; iob_wstrb_i = 4'h0;
    @(posedge clk_i);
    #2;
    arst_n_i = 1'b0;
    #1;
    nchk++; if ({iob_rvalid_o, halt_o, iob_ready_o} !== 3'b000) begin
      nfail++; $display("FAIL async_reset_ctl: got rvalid/halt/ready=%b required 000", {iob_rvalid_o, halt_o, iob_ready_o});
    end
    nchk++; if (iob_rdata_o !== 32'h0) begin
      nfail++; $display("FAIL async_reset_rdata: got %h required 0", iob_rdata_o);
    end
    iob_avalid_i = 1'b0;
    trap_i = 1'b0;
    repeat (2) @(negedge clk_i);
    arst_n_i = 1'b1;
    rvs = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (iob_rvalid_o) rvs++;
    end
    nchk++; if (rvs != 0) begin
      nfail++; $display("FAIL no_rvalid_after_reset: got %0d required 0", rvs);
    end
    csr_read(6'd32, d, rv);
    nchk++; if (d !== 32'h0) begin
      nfail++; $display("FAIL status_after_reset: got %h required 0", d);
    end
    csr_read(6'd12, d, rv);
    nchk++; if (d !== 32'h0) begin
      nfail++; $display("FAIL count1_after_reset: got %h required 0", d);
    end
    csr_read(6'd0, d, rv);
    nchk++; if (d !== 32'h0) begin
      nfail++; $display("FAIL addr0_after_reset: got %h required 0", d);
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_rw_map();
    test_write_match();
    test_threshold();
    test_back_to_back();
    test_cke();
    test_trap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
